// File: rtl/ctrl_poller_pkg.sv
// Shared NES joypad definitions: poller FSM states and button bit positions.
// Used by the poller, the pad responder model and the $4016 shadow logic.
package nes_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STROBE,
    ST_LOW,
    ST_RD_HI,
    ST_DONE
  } ctrl_state_t;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
  localparam int NUM_BTNS   = 8;

endpackage

// File: rtl/ctrl_poller_if.sv
// Joypad poller bus: poll request, pad pins and published button byte.
// master = poller side, slave = pad/CPU side.
interface ctrl_poller_if;
  import nes_ctrl_pkg::*;

  logic                start;
  logic                ctrl_strobe;
  logic                ctrl_rd;
  logic                ctrl_data;
  logic [NUM_BTNS-1:0] btns;
  logic                btns_valid;
  logic                busy;

  modport master (
    input  start,
    input  ctrl_data,
    output ctrl_strobe,
    output ctrl_rd,
    output btns,
    output btns_valid,
    output busy
  );

  modport slave (
    output start,
    output ctrl_data,
    input  ctrl_strobe,
    input  ctrl_rd,
    input  btns,
    input  btns_valid,
    input  busy
  );

endinterface

// File: rtl/ctrl_poller_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
// Resets to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ctrl_poller.sv
// NES serial joypad initiator: strobe, 7 read clocks, 8 LSB-first samples.
// Publishes one button byte per poll with a single-cycle valid pulse.
module ctrl_poller
  import nes_ctrl_pkg::*;
#(
  parameter int HALF_PERIOD     = 6,
  parameter int AUTO_PERIOD     = 0,
  parameter bit DATA_ACTIVE_LOW = 1'b0
) (
  input logic           clk,
  input logic           rst,
  ctrl_poller_if.master bus
);

  localparam int HC_W  = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int AT_W  = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
  localparam int BIT_W = $clog2(NUM_BTNS);

  ctrl_state_t         state_q, state_d;
  logic [HC_W-1:0]     hc_q, hc_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [NUM_BTNS-1:0] sh_q, sh_d;
  logic [NUM_BTNS-1:0] btns_q;
  logic                strobe_q, rd_q;
  logic                valid_q, busy_q;
  logic                pend_q;
  logic                data_s;
  logic                accept;
  logic                last_hc;
  logic                done_enter;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.ctrl_data),
    .q_o (data_s)
  );

  assign last_hc = (hc_q == HC_W'(HALF_PERIOD - 1));

  always_comb begin
    state_d    = state_q;
    hc_d       = hc_q;
    bit_d      = bit_q;
    sh_d       = sh_q;
    accept     = 1'b0;
    done_enter = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start || pend_q) begin
          accept  = 1'b1;
          state_d = ST_STROBE;
          hc_d    = '0;
          bit_d   = '0;
        end
      end
      ST_STROBE: begin
        hc_d = hc_q + 1'b1;
        if (last_hc) begin
          hc_d    = '0;
          state_d = ST_LOW;
        end
      end
      ST_LOW: begin
        hc_d = hc_q + 1'b1;
        if (last_hc) begin
          hc_d        = '0;
          sh_d[bit_q] = data_s;
          if (bit_q == BIT_W'(NUM_BTNS - 1)) begin
            state_d    = ST_DONE;
            done_enter = 1'b1;
          end else begin
            state_d = ST_RD_HI;
            bit_d   = bit_q + 1'b1;
          end
        end
      end
      ST_RD_HI: begin
        hc_d = hc_q + 1'b1;
        if (last_hc) begin
          hc_d    = '0;
          state_d = ST_LOW;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Pin and status flops take the next state so outputs line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      hc_q     <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      btns_q   <= '0;
      strobe_q <= 1'b0;
      rd_q     <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hc_q     <= hc_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      strobe_q <= (state_d == ST_STROBE);
      rd_q     <= (state_d == ST_RD_HI);
      valid_q  <= done_enter;
      busy_q   <= (state_d != ST_IDLE);
      if (done_enter) begin
        btns_q <= DATA_ACTIVE_LOW ? ~sh_d : sh_d;
      end
    end
  end

  generate
    if (AUTO_PERIOD > 0) begin : g_auto
      logic [AT_W-1:0] at_q;
      logic            wrap;

      assign wrap = (at_q == AT_W'(AUTO_PERIOD - 1));

      // A fresh wrap wins over a same-cycle accept.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          at_q   <= '0;
          pend_q <= 1'b0;
        end else begin
          at_q <= wrap ? '0 : at_q + 1'b1;
          if (wrap) begin
            pend_q <= 1'b1;
          end else if (accept) begin
            pend_q <= 1'b0;
          end
        end
      end
    end else begin : g_no_auto
      assign pend_q = 1'b0;
    end
  endgenerate

  assign bus.ctrl_strobe = strobe_q;
  assign bus.ctrl_rd     = rd_q;
  assign bus.btns        = btns_q;
  assign bus.btns_valid  = valid_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_ctrl_poller.sv
// Scoreboard bench: three pollers, each wired to a shift-register pad model.
// Expected bytes and completion cycles are queued at stimulus, checked on valid.
module tb_ctrl_poller;

  typedef struct {
    int         cyc;
    logic [7:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a, rst_b, rst_c;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ctrl_poller_if if_a ();
  ctrl_poller_if if_b ();
  ctrl_poller_if if_c ();

  ctrl_poller #(.HALF_PERIOD(6), .AUTO_PERIOD(0), .DATA_ACTIVE_LOW(1'b0))
    u_a (.clk(clk), .rst(rst_a), .bus(if_a));
  ctrl_poller #(.HALF_PERIOD(6), .AUTO_PERIOD(0), .DATA_ACTIVE_LOW(1'b1))
    u_b (.clk(clk), .rst(rst_b), .bus(if_b));
  ctrl_poller #(.HALF_PERIOD(6), .AUTO_PERIOD(200), .DATA_ACTIVE_LOW(1'b0))
    u_c (.clk(clk), .rst(rst_c), .bus(if_c));

  // Pad models: load while strobe high, shift on rd rising edge.
  logic [7:0] pin_a, pin_b, pin_c;
  logic [7:0] sh_a = 8'hFF, sh_b = 8'hFF, sh_c = 8'hFF;
  logic       rdp_a = 1'b0, rdp_b = 1'b0, rdp_c = 1'b0;

  always @(posedge clk) begin
    rdp_a <= if_a.ctrl_rd;
    rdp_b <= if_b.ctrl_rd;
    rdp_c <= if_c.ctrl_rd;
    if (if_a.ctrl_strobe) sh_a <= pin_a;
    else if (if_a.ctrl_rd && !rdp_a) sh_a <= {1'b1, sh_a[7:1]};
    if (if_b.ctrl_strobe) sh_b <= pin_b;
    else if (if_b.ctrl_rd && !rdp_b) sh_b <= {1'b1, sh_b[7:1]};
    if (if_c.ctrl_strobe) sh_c <= pin_c;
    else if (if_c.ctrl_rd && !rdp_c) sh_c <= {1'b1, sh_c[7:1]};
  end

  assign if_a.ctrl_data = sh_a[0];
  assign if_b.ctrl_data = sh_b[0];
  assign if_c.ctrl_data = sh_c[0];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at cycle %0d",
               nm, act, act, exp, exp, cyc);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: pop and compare whenever a DUT presents btns_valid.
  int rdlen = 0;
  int rdcnt = 0;

  always @(negedge clk) begin
    exp_t e;
    assert (!(if_a.ctrl_strobe && if_a.ctrl_rd));
    assert (!(if_b.ctrl_strobe && if_b.ctrl_rd));
    assert (!(if_c.ctrl_strobe && if_c.ctrl_rd));
    if (rst_a) begin
      rdlen = 0;
      rdcnt = 0;
    end else if (if_a.ctrl_rd) begin
      rdlen++;
    end else if (rdlen > 0) begin
      chk("a_rd_width", rdlen, 6);
      rdcnt++;
      rdlen = 0;
    end
    if (if_a.btns_valid) begin
      chk("a_valid_expected", int'(q_a.size() > 0), 1);
      chk("a_rd_pulses", rdcnt, 7);
      rdcnt = 0;
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        chk("a_btns", int'(if_a.btns), int'(e.val));
        chk("a_valid_cycle", cyc, e.cyc);
      end
    end
    if (if_b.btns_valid) begin
      chk("b_valid_expected", int'(q_b.size() > 0), 1);
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        chk("b_btns", int'(if_b.btns), int'(e.val));
        chk("b_valid_cycle", cyc, e.cyc);
      end
    end
    if (if_c.btns_valid) begin
      chk("c_valid_expected", int'(q_c.size() > 0), 1);
      if (q_c.size() > 0) begin
        e = q_c.pop_front();
        chk("c_btns", int'(if_c.btns), int'(e.val));
        chk("c_valid_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic poll_a(input logic [7:0] v, input bit expect_done,
                        output int n);
    pin_a = v;
    @(posedge clk);
    #1;
    n = cyc;
    if_a.start = 1'b1;
    if (expect_done) q_a.push_back('{n + 97, v});
    @(posedge clk);
    #1;
    if_a.start = 1'b0;
  endtask

  initial begin
    int n;
    int r;
    rst_a = 1'b1;
    rst_b = 1'b1;
    rst_c = 1'b1;
    if_a.start = 1'b0;
    if_b.start = 1'b0;
    if_c.start = 1'b0;
    pin_a = 8'h00;
    pin_b = 8'h00;
    pin_c = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;
    @(negedge clk);
    chk("rst_strobe", int'(if_a.ctrl_strobe), 0);
    chk("rst_rd", int'(if_a.ctrl_rd), 0);
    chk("rst_btns", int'(if_a.btns), 0);
    chk("rst_valid", int'(if_a.btns_valid), 0);
    chk("rst_busy", int'(if_a.busy), 0);

    // Single poll, latency and busy window
    poll_a(8'h04, 1'b1, n);
    wait_until(n + 1);
    chk("t1_busy_c1", int'(if_a.busy), 1);
    chk("t1_strobe_c1", int'(if_a.ctrl_strobe), 1);
    wait_until(n + 97);
    chk("t1_busy_c97", int'(if_a.busy), 1);
    wait_until(n + 98);
    chk("t1_busy_c98", int'(if_a.busy), 0);
    chk("t1_btns_hold", int'(if_a.btns), 8'h04);

    // Reset mid-poll at cycle 40 (rd high), then a clean poll
    poll_a(8'h99, 1'b0, n);
    wait_until(n + 40);
    chk("t5_rd_before", int'(if_a.ctrl_rd), 1);
    chk("t5_btns_before", int'(if_a.btns), 8'h04);
    rst_a = 1'b1;
    #1;
    chk("t5_rst_strobe", int'(if_a.ctrl_strobe), 0);
    chk("t5_rst_rd", int'(if_a.ctrl_rd), 0);
    chk("t5_rst_btns", int'(if_a.btns), 0);
    chk("t5_rst_busy", int'(if_a.busy), 0);
    @(negedge clk);
    rst_a = 1'b0;
    poll_a(8'h42, 1'b1, n);
    wait_until(n + 98);
    chk("t5_btns_after", int'(if_a.btns), 8'h42);

    // Back-to-back polls; btns holds old value mid-poll
    poll_a(8'hA5, 1'b1, n);
    wait_until(n + 98);
    poll_a(8'h5A, 1'b1, n);
    wait_until(n + 50);
    chk("t2_btns_mid", int'(if_a.btns), 8'hA5);
    wait_until(n + 98);
    chk("t2_btns_end", int'(if_a.btns), 8'h5A);

    // start re-pulsed while busy is ignored
    poll_a(8'h3C, 1'b1, n);
    wait_until(n + 10);
    if_a.start = 1'b1;
    @(negedge clk);
    if_a.start = 1'b0;
    wait_until(n + 50);
    if_a.start = 1'b1;
    @(negedge clk);
    if_a.start = 1'b0;
    wait_until(n + 120);
    chk("t4_busy_after", int'(if_a.busy), 0);
    chk("t4_btns", int'(if_a.btns), 8'h3C);

    // Active-low pad: only A pressed
    pin_b = 8'hFE;
    @(posedge clk);
    #1;
    n = cyc;
    if_b.start = 1'b1;
    q_b.push_back('{n + 97, 8'h01});
    @(posedge clk);
    #1;
    if_b.start = 1'b0;
    wait_until(n + 98);
    chk("t3_btns", int'(if_b.btns), 8'h01);

    // Auto polling every 200 cycles, start tied low
    pin_c = 8'h81;
    @(posedge clk);
    #1;
    rst_c = 1'b0;
    r = cyc;
    q_c.push_back('{r + 297, 8'h81});
    q_c.push_back('{r + 497, 8'h81});
    q_c.push_back('{r + 697, 8'h81});
    wait_until(r + 600);
    chk("t6_btns_mid", int'(if_c.btns), 8'h81);
    wait_until(r + 720);
    rst_c = 1'b1;

    @(negedge clk);
    chk("q_a_drained", q_a.size(), 0);
    chk("q_b_drained", q_b.size(), 0);
    chk("q_c_drained", q_c.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
